// File: rtl/cci_csr_regfile.sv
// MMIO CSR register file: decodes CCI-P MMIO reads/writes into N_CSRS 64-bit registers.
// Optional read-to-clear behaviour is enabled with the CCI_CSR_RDCLR_EN macro.
module cci_csr_regfile #(
  parameter int          N_CSRS   = 8,
  parameter logic [15:0] CSR_BASE = 16'h0020,
  parameter logic [63:0] RO_MASK  = 64'h0,
  parameter logic [63:0] RST_VAL  = 64'h0
`ifdef CCI_CSR_RDCLR_EN
  ,
  parameter logic [63:0] RDCLR_MASK = 64'h0
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mmio_wr_valid,
  input  logic                  mmio_rd_valid,
  input  logic [15:0]           mmio_addr,
  input  logic                  mmio_len64,
  input  logic [8:0]            mmio_tid,
  input  logic [63:0]           mmio_wr_data,
  input  logic [64*N_CSRS-1:0]  csr_ro_in,
  output logic [64*N_CSRS-1:0]  csr_q,
  output logic [N_CSRS-1:0]     csr_wr_pulse,
  output logic                  rsp_valid,
  output logic [8:0]            rsp_tid,
  output logic [63:0]           rsp_data
);

  localparam int IDX_W = (N_CSRS > 1) ? $clog2(N_CSRS) : 1;

  // Requests are single-cycle valid pulses with no ready: every read gets
  // exactly one response two cycles later, every write is applied at the next edge.
  logic [15:0]      w_off;
  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  logic             w_half;
  logic             w_wr_acc;
  logic [63:0]      w_rd_raw;
  logic [63:0]      w_rsp_fmt;

  assign w_off    = mmio_addr - CSR_BASE;
  assign w_hit    = (mmio_addr >= CSR_BASE) && ({1'b0, w_off[15:1]} < 16'(N_CSRS));
  assign w_idx    = w_off[IDX_W:1];
  assign w_half   = w_off[0];
  assign w_wr_acc = mmio_wr_valid && w_hit && !(mmio_len64 && w_half);

`ifdef CCI_CSR_RDCLR_EN
  logic w_rd_clr;
  assign w_rd_clr = mmio_rd_valid && w_hit && mmio_len64 && !w_half;
`endif

  logic [63:0]       r_csr [N_CSRS];
  logic [N_CSRS-1:0] r_wr_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CSRS; i++) r_csr[i] <= RST_VAL;
      r_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < N_CSRS; i++) begin
        r_wr_pulse[i] <= w_wr_acc && (w_idx == IDX_W'(i));
        if (!RO_MASK[i]) begin
          if (w_wr_acc && (w_idx == IDX_W'(i))) begin
            if (mmio_len64)  r_csr[i]        <= mmio_wr_data;
            else if (w_half) r_csr[i][63:32] <= mmio_wr_data[31:0];
            else             r_csr[i][31:0]  <= mmio_wr_data[31:0];
          end
`ifdef CCI_CSR_RDCLR_EN
          // A write in the same cycle takes priority over the clear.
          else if (w_rd_clr && RDCLR_MASK[i] && (w_idx == IDX_W'(i))) begin
            r_csr[i] <= '0;
          end
`endif
        end
      end
    end
  end

  always_comb begin
    w_rd_raw = '0;
    for (int i = 0; i < N_CSRS; i++) begin
      if (w_idx == IDX_W'(i)) w_rd_raw = RO_MASK[i] ? csr_ro_in[64*i +: 64] : r_csr[i];
    end
  end

  // S1 captures register contents at the request edge, so a same-cycle write is not visible.
  logic        r_s1_valid;
  logic [8:0]  r_s1_tid;
  logic [63:0] r_s1_data;
  logic        r_s1_hit;
  logic        r_s1_half;
  logic        r_s1_len64;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_tid   <= '0;
      r_s1_data  <= '0;
      r_s1_hit   <= 1'b0;
      r_s1_half  <= 1'b0;
      r_s1_len64 <= 1'b0;
    end else begin
      r_s1_valid <= mmio_rd_valid;
      if (mmio_rd_valid) begin
        r_s1_tid   <= mmio_tid;
        r_s1_data  <= w_rd_raw;
        r_s1_hit   <= w_hit;
        r_s1_half  <= w_half;
        r_s1_len64 <= mmio_len64;
      end
    end
  end

  always_comb begin
    w_rsp_fmt = '0;
    if (r_s1_hit) begin
      if (r_s1_len64)     w_rsp_fmt = r_s1_half ? 64'h0 : r_s1_data;
      else if (r_s1_half) w_rsp_fmt = {32'h0, r_s1_data[63:32]};
      else                w_rsp_fmt = {32'h0, r_s1_data[31:0]};
    end
  end

  logic        r_rsp_valid;
  logic [8:0]  r_rsp_tid;
  logic [63:0] r_rsp_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_tid   <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rsp_tid  <= r_s1_tid;
        r_rsp_data <= w_rsp_fmt;
      end
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_tid      = r_rsp_tid;
  assign rsp_data     = r_rsp_data;
  assign csr_wr_pulse = r_wr_pulse;

  for (genvar g = 0; g < N_CSRS; g++) begin : g_csr_q
    assign csr_q[64*g +: 64] = RO_MASK[g] ? 64'h0 : r_csr[g];
  end

endmodule

// File: tb/tb_cci_csr_regfile.sv
// Bench for cci_csr_regfile: directed MMIO traffic, response scoreboard with latency check.
// Exercises the CCI_CSR_RDCLR_EN variant when that macro is defined.
module tb_cci_csr_regfile;

  localparam int N = 8;
  localparam int W = 73;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           mmio_wr_valid = 1'b0;
  logic           mmio_rd_valid = 1'b0;
  logic [15:0]    mmio_addr = '0;
  logic           mmio_len64 = 1'b0;
  logic [8:0]     mmio_tid = '0;
  logic [63:0]    mmio_wr_data = '0;
  logic [64*N-1:0] csr_ro_in = '0;
  logic [64*N-1:0] csr_q;
  logic [N-1:0]   csr_wr_pulse;
  logic           rsp_valid;
  logic [8:0]     rsp_tid;
  logic [63:0]    rsp_data;

  cci_csr_regfile #(
    .N_CSRS(N),
    .CSR_BASE(16'h0020),
    .RO_MASK(64'h80),
    .RST_VAL(64'h0)
`ifdef CCI_CSR_RDCLR_EN
    ,
    .RDCLR_MASK(64'h1)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .mmio_wr_valid(mmio_wr_valid),
    .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr),
    .mmio_len64(mmio_len64),
    .mmio_tid(mmio_tid),
    .mmio_wr_data(mmio_wr_data),
    .csr_ro_in(csr_ro_in),
    .csr_q(csr_q),
    .csr_wr_pulse(csr_wr_pulse),
    .rsp_valid(rsp_valid),
    .rsp_tid(rsp_tid),
    .rsp_data(rsp_data)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit push_en = 1'b1;
  logic [W-1:0] exp_q[$];
  int exp_cyc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit wr, input bit rd, input logic [15:0] addr, input bit len,
                       input logic [8:0] tid, input logic [63:0] wdata, input logic [63:0] exp_data);
    @(negedge clk);
    mmio_wr_valid = wr;
    mmio_rd_valid = rd;
    mmio_addr     = addr;
    mmio_len64    = len;
    mmio_tid      = tid;
    mmio_wr_data  = wdata;
    if (rd && push_en) begin
      exp_q.push_back({tid, exp_data});
      exp_cyc_q.push_back(cyc + 2);
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 9'h0, 64'h0, 64'h0);
  endtask

  task automatic wr(input logic [15:0] addr, input bit len, input logic [63:0] wdata);
    drive(1'b1, 1'b0, addr, len, 9'h0, wdata, 64'h0);
  endtask

  task automatic rd(input logic [15:0] addr, input bit len, input logic [8:0] tid, input logic [63:0] exp);
    drive(1'b0, 1'b1, addr, len, tid, 64'h0, exp);
  endtask

  task automatic chk_all_csr(input string name, input logic [64*N-1:0] exp);
    for (int k = 0; k < N; k++) chk($sformatf("%s_csr%0d", name, k), csr_q[64*k +: 64], exp[64*k +: 64]);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      idle();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses, required 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    int ec;
    if (rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got tid %h data %h, required no response", rsp_tid, rsp_data);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if ({rsp_tid, rsp_data} !== e || cyc != ec) begin
          errors++;
          $display("FAIL rsp: got tid %h data %h cycle %0d, required tid %h data %h cycle %0d",
                   rsp_tid, rsp_data, cyc, e[72:64], e[63:0], ec);
        end
      end
    end
  end

  logic [64*N-1:0] exp_vec;
  logic [63:0] old0;

  initial begin
    csr_ro_in[64*7 +: 64] = 64'h1111_2222_3333_4444;
    repeat (3) @(negedge clk);
    chk_all_csr("reset", '0);
    chk("reset_pulse", 64'(csr_wr_pulse), 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    reset = 1'b0;

    rd(16'h0020, 1'b1, 9'd5, 64'h0);

    wr(16'h0022, 1'b1, 64'hDEAD_BEEF_0123_4567);
    idle();
    chk("wr64_pulse", 64'(csr_wr_pulse), 64'h02);
    chk("wr64_csr1", csr_q[64*1 +: 64], 64'hDEAD_BEEF_0123_4567);
    idle();
    chk("wr64_pulse_drop", 64'(csr_wr_pulse), 64'h0);

    rd(16'h0022, 1'b1, 9'd1, 64'hDEAD_BEEF_0123_4567);
    rd(16'h0023, 1'b0, 9'd2, 64'h0000_0000_DEAD_BEEF);
    rd(16'h0022, 1'b0, 9'd3, 64'h0000_0000_0123_4567);
    rd(16'h0023, 1'b1, 9'd4, 64'h0);

    wr(16'h0025, 1'b0, 64'hFFFF_FFFF_CAFE_F00D);
    idle();
    chk("wr32_pulse", 64'(csr_wr_pulse), 64'h04);
    chk("wr32_csr2", csr_q[64*2 +: 64], 64'hCAFE_F00D_0000_0000);

    wr(16'h0027, 1'b1, 64'h1234);
    idle();
    chk("wr64_odd_pulse", 64'(csr_wr_pulse), 64'h0);
    chk("wr64_odd_csr3", csr_q[64*3 +: 64], 64'h0);

    drive(1'b1, 1'b1, 16'h0024, 1'b1, 9'd6, 64'h1, 64'hCAFE_F00D_0000_0000);
    rd(16'h0024, 1'b1, 9'd7, 64'h1);

    rd(16'h0030, 1'b1, 9'h1FF, 64'h0);
    rd(16'h001F, 1'b1, 9'h010, 64'h0);
    wr(16'h0010, 1'b1, 64'h5555_5555_5555_5555);
    idle();
    chk("miss_pulse", 64'(csr_wr_pulse), 64'h0);
    exp_vec = '0;
    exp_vec[64*1 +: 64] = 64'hDEAD_BEEF_0123_4567;
    exp_vec[64*2 +: 64] = 64'h1;
    chk_all_csr("miss", exp_vec);

    rd(16'h002E, 1'b1, 9'd8, 64'h1111_2222_3333_4444);
    rd(16'h002F, 1'b0, 9'd11, 64'h0000_0000_1111_2222);
    wr(16'h002E, 1'b1, 64'h9999);
    idle();
    chk("ro_pulse", 64'(csr_wr_pulse), 64'h80);
    chk("ro_csr7", csr_q[64*7 +: 64], 64'h0);

    rd(16'h0022, 1'b1, 9'd9, 64'hDEAD_BEEF_0123_4567);
    rd(16'h0024, 1'b1, 9'd10, 64'h1);

    wr(16'h0020, 1'b1, 64'h7);
`ifdef CCI_CSR_RDCLR_EN
    old0 = 64'h0;
`else
    old0 = 64'h7;
`endif
    rd(16'h0020, 1'b1, 9'd12, 64'h7);
    rd(16'h0020, 1'b1, 9'd13, old0);
    drive(1'b1, 1'b1, 16'h0020, 1'b1, 9'd14, 64'h9, old0);
    rd(16'h0020, 1'b1, 9'd15, 64'h9);
    idle();
    chk("rdclr_wr_wins_csr0", csr_q[64*0 +: 64], 64'h9);
    drain();

    // read in flight when reset hits: no response may appear afterwards
    push_en = 1'b0;
    rd(16'h0022, 1'b1, 9'd20, 64'h0);
    push_en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    mmio_rd_valid = 1'b0;
    mmio_wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
    reset = 1'b0;
    repeat (4) idle();
    chk_all_csr("midrst", '0);
    rd(16'h0022, 1'b1, 9'd21, 64'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
